seg_scan_driver: RTL and testbench

Consumes the eight BCD digits (HH MM SS cc) and the per-digit enable mask produced by the clock/config controller and drives a common-anode, time-multiplexed 8-digit 7-segment display. It snapshots the digit values once per scan frame, so a frame never mixes old and new time. It scans one digit at a time with a programmable on-time and an anti-ghosting blank gap. It sits between the controller and the board pins.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_scan_driver_if.sv | 32 +++
 rtl/bcd_to_seg.sv | 28 ++
 rtl/seg_scan_driver.sv | 128 ++++++++++++
 tb/tb_seg_scan_driver.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

   typedef enum logic {
      ST_BLANK,
      ST_SCAN
   } state_e;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   // Digits carrying a decimal point: HH.MM.SS.cc
   localparam logic [7:0] DP_MASK  = 8'b0101_0100;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Controller-to-display bundle: BCD digits and enable mask in,
// anode/segment/dp pins out.
interface seg_scan_driver_if;

   logic [3:0] i_num7;
   logic [3:0] i_num6;
   logic [3:0] i_num5;
   logic [3:0] i_num4;
   logic [3:0] i_num3;
   logic [3:0] i_num2;
   logic [3:0] i_num1;
   logic [3:0] i_num0;
   logic [7:0] i_digit_en;
   logic [7:0] o_an;
   logic [6:0] o_seg;
   logic       o_dp;

   modport master (
      output i_num7, i_num6, i_num5, i_num4,
      output i_num3, i_num2, i_num1, i_num0,
      output i_digit_en,
      input  o_an, o_seg, o_dp
   );

   modport slave (
      input  i_num7, i_num6, i_num5, i_num4,
      input  i_num3, i_num2, i_num1, i_num0,
      input  i_digit_en,
      output o_an, o_seg, o_dp
   );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 render as a dash.
module bcd_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // Lookup of the segment pattern for one digit
   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment scan driver.
// Optional macro SEG_LEAD_ZERO_BLANK_EN darkens digit 7 when it is 0.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int SCAN_CYC  = 250,
   parameter int BLANK_CYC = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   seg_scan_driver_if.slave bus
);

   localparam int MAXC = (SCAN_CYC > BLANK_CYC) ? SCAN_CYC : BLANK_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_CYC - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [3:0]    snap_q [8];
   logic [3:0]    snap_d [8];
   logic [7:0]    en_q, en_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic [3:0]    num_in [8];
   logic [7:0]    en_eff;
   logic [3:0]    sel_bcd;
   logic [6:0]    dec_seg;

   assign num_in[7] = bus.i_num7;
   assign num_in[6] = bus.i_num6;
   assign num_in[5] = bus.i_num5;
   assign num_in[4] = bus.i_num4;
   assign num_in[3] = bus.i_num3;
   assign num_in[2] = bus.i_num2;
   assign num_in[1] = bus.i_num1;
   assign num_in[0] = bus.i_num0;

   // Scan sequencing; frame snapshot taken as digit 7 lights
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      snap_d  = snap_q;
      en_d    = en_q;
      unique case (state_q)
         ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = ST_SCAN;
               cnt_d   = '0;
               if (idx_q == 3'd7) begin
                  snap_d = num_in;
                  en_d   = bus.i_digit_en;
               end
            end
         end
         ST_SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               idx_d   = idx_q - 3'd1;
            end
         end
      endcase
   end

   // Effective enable, with optional leading-zero suppression
   always_comb begin
      en_eff = en_d;
`ifdef SEG_LEAD_ZERO_BLANK_EN
      if (snap_d[7] == 4'd0) begin
         en_eff[7] = 1'b0;
      end
`endif
   end

   assign sel_bcd = snap_d[idx_q];

   bcd_to_seg u_dec (
      .i_bcd (sel_bcd),
      .o_seg (dec_seg)
   );

   // Pin values follow the next state so they switch with it
   always_comb begin
      an_d  = 8'hFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (state_d == ST_SCAN && en_eff[idx_q]) begin
         an_d  = ~(8'b1 << idx_q);
         seg_d = dec_seg;
         dp_d  = ~DP_MASK[idx_q];
      end
   end

   // State, counters, snapshot and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         idx_q   <= 3'd7;
         snap_q  <= '{default: 4'd0};
         en_q    <= 8'h00;
         an_q    <= 8'hFF;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         en_q    <= en_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign bus.o_an  = an_q;
   assign bus.o_seg = seg_q;
   assign bus.o_dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with SCAN_CYC=4, BLANK_CYC=2.
// Frame vectors feed a scoreboard checked slot by slot.
module tb_seg_scan_driver;

   localparam int SC = 4;
   localparam int BC = 2;
   localparam int DP = SC + BC;
   localparam int FR = 8 * DP;
   localparam int NF = 6;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SO = 7'b1111111;
`ifdef SEG_LEAD_ZERO_BLANK_EN
   localparam logic [6:0] LZ = SO;
`else
   localparam logic [6:0] LZ = S0;
`endif

   typedef struct {
      logic [31:0] nums;
      logic [7:0]  en;
      logic [55:0] segs;
   } vec_t;

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   vec_t vecs [NF];
   exp_t sb [$];
   exp_t cur;

   seg_scan_driver_if bus ();

   seg_scan_driver #(
      .SCAN_CYC  (SC),
      .BLANK_CYC (BC)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int k, input logic [7:0] ea,
                      input logic [6:0] es, input logic ed);
      n_chk++;
      if (bus.o_an !== ea || bus.o_seg !== es || bus.o_dp !== ed) begin
         n_fail++;
         $display("FAIL %s k=%0d got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b",
                  nm, k, bus.o_an, bus.o_seg, bus.o_dp, ea, es, ed);
      end
   endtask

   task automatic apply(input int f);
      exp_t e;
      bus.i_num7     = vecs[f].nums[31:28];
      bus.i_num6     = vecs[f].nums[27:24];
      bus.i_num5     = vecs[f].nums[23:20];
      bus.i_num4     = vecs[f].nums[19:16];
      bus.i_num3     = vecs[f].nums[15:12];
      bus.i_num2     = vecs[f].nums[11:8];
      bus.i_num1     = vecs[f].nums[7:4];
      bus.i_num0     = vecs[f].nums[3:0];
      bus.i_digit_en = vecs[f].en;
      for (int d = 7; d >= 0; d--) begin
         e.seg = vecs[f].segs[7*d +: 7];
         if (e.seg == SO) begin
            e.an = 8'hFF;
            e.dp = 1'b1;
         end else begin
            e.an = ~(8'b1 << d);
            e.dp = (d == 6 || d == 4 || d == 2) ? 1'b0 : 1'b1;
         end
         sb.push_back(e);
      end
   endtask

   initial begin
      int k;
      int p;
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      cur    = '{an: 8'hFF, seg: SO, dp: 1'b1};

      vecs[0] = '{32'h2359_5999, 8'hFF, {S2, S3, S5, S9, S5, S9, S9, S9}};
      vecs[1] = '{32'h2359_5991, 8'hFF, {S2, S3, S5, S9, S5, S9, S9, S1}};
      vecs[2] = '{32'h2359_5991, 8'hBF, {S2, SO, S5, S9, S5, S9, S9, S1}};
      vecs[3] = '{32'h8888_8888, 8'h5A, {SO, S8, SO, S8, S8, SO, S8, SO}};
      vecs[4] = '{32'h0123_C567, 8'hFF, {LZ, S1, S2, S3, SD, S5, S6, S7}};
      vecs[5] = '{32'h1084_9670, 8'hFF, {S1, S0, S8, S4, S9, S6, S7, S0}};

      apply(0);
      repeat (3) @(negedge clk);
      chk("reset_state", -1, 8'hFF, SO, 1'b1);

      rst_n = 1'b1;
      k = 0;
      chk("blank", k, 8'hFF, SO, 1'b1);
      for (k = 1; k < NF * FR; k++) begin
         @(negedge clk);
         p = k % DP;
         if (p < BC) begin
            chk("blank", k, 8'hFF, SO, 1'b1);
         end else if (p == BC) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_empty k=%0d got no entry want entry", k);
            end else begin
               cur = sb.pop_front();
               chk("slot_start", k, cur.an, cur.seg, cur.dp);
            end
         end else begin
            chk("slot_hold", k, cur.an, cur.seg, cur.dp);
         end
         if (k % FR == 20 && k / FR + 1 < NF) begin
            apply(k / FR + 1);
         end
      end

      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain got %0d left want 0", sb.size());
      end

      while (k < NF * FR + 4 * DP + BC + 1) begin
         @(negedge clk);
         k++;
      end
      chk("pre_rst_d3", k, 8'hF7, S9, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", k, 8'hFF, SO, 1'b1);
      @(negedge clk);
      chk("rst_hold", k, 8'hFF, SO, 1'b1);
      rst_n = 1'b1;
      #1 chk("restart", 0, 8'hFF, SO, 1'b1);
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         if (j < 2 || j == 6 || j == 7) begin
            chk("restart_blank", j, 8'hFF, SO, 1'b1);
         end else if (j < 6) begin
            chk("restart_d7", j, 8'h7F, S1, 1'b1);
         end else begin
            chk("restart_d6", j, 8'hBF, S0, 1'b0);
         end
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
